// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings and widths used across the decoder, memory and write-back stages.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    // Write-back source select.
    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

    // Load access size; 11 behaves as a word.
    typedef enum logic [1:0] {
        SEC_B  = 2'b00,
        SEC_H  = 2'b01,
        SEC_W  = 2'b10,
        SEC_WX = 2'b11
    } data_sec_e;

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: one write port, two async read ports with write-through bypass, x0 hardwired to 0.
module regfile
    import riscv_pkg::*;
#(
    parameter bit CLR_REGS_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage update: optional clear on reset, never write x0, no write in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLR_REGS_ON_RST) begin
                for (int i = 0; i < int'(NREGS); i++) begin
                    regs[i] <= '0;
                end
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1: x0 reads zero, a same-cycle write to the address is forwarded.
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: aligns control with the memory stage outputs, selects and extends the result, writes the register file.
module wb_stage
    import riscv_pkg::*;
#(
    parameter bit CLR_REGS_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              regWEn_i,
    input  logic [1:0]        wbSel_i,
    input  logic              loadSigned_i,
    input  logic [1:0]        dataSec_i,
    input  logic [XLEN-1:0]   pc4_i,
    input  logic [XLEN-1:0]   memData_i,
    input  logic [XLEN-1:0]   aluRes_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    output logic [XLEN-1:0]   rs1Data_o,
    output logic [XLEN-1:0]   rs2Data_o,
    output logic [XLEN-1:0]   wbData_o,
    output logic [REG_AW-1:0] wbRd_o,
    output logic              wbEn_o
);

    logic [REG_AW-1:0] rd_q;
    logic              regwen_q;
    wb_sel_e           wbsel_q;
    logic              loadsigned_q;
    data_sec_e         datasec_q;
    logic [XLEN-1:0]   pc4_q;
    logic [XLEN-1:0]   load_val;

    // Control register: reset dominates, flush kills the write enable, stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q         <= '0;
            regwen_q     <= 1'b0;
            wbsel_q      <= WB_ALU;
            loadsigned_q <= 1'b0;
            datasec_q    <= SEC_B;
            pc4_q        <= '0;
        end else if (flush_i) begin
            regwen_q     <= 1'b0;
        end else if (!stall_i) begin
            rd_q         <= rd_i;
            regwen_q     <= regWEn_i;
            wbsel_q      <= wb_sel_e'(wbSel_i);
            loadsigned_q <= loadSigned_i;
            datasec_q    <= data_sec_e'(dataSec_i);
            pc4_q        <= pc4_i;
        end
    end

    // Load data sizing and sign/zero extension.
    always_comb begin
        load_val = memData_i;
        case (datasec_q)
            SEC_B:   load_val = {{24{loadsigned_q & memData_i[7]}}, memData_i[7:0]};
            SEC_H:   load_val = {{16{loadsigned_q & memData_i[15]}}, memData_i[15:0]};
            default: load_val = memData_i;
        endcase
    end

    // Write-back source mux; the reserved encoding writes zero.
    always_comb begin
        wbData_o = '0;
        case (wbsel_q)
            WB_MEM:  wbData_o = load_val;
            WB_ALU:  wbData_o = aluRes_i;
            WB_PC4:  wbData_o = pc4_q;
            default: wbData_o = '0;
        endcase
    end

    assign wbRd_o = rd_q;
    assign wbEn_o = regwen_q & (rd_q != '0) & ~stall_i;

    regfile #(
        .CLR_REGS_ON_RST (CLR_REGS_ON_RST)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wbEn_o),
        .waddr  (wbRd_o),
        .wdata  (wbData_o),
        .raddr1 (rs1_i),
        .raddr2 (rs2_i),
        .rdata1 (rs1Data_o),
        .rdata2 (rs2Data_o)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  rd_i;
    logic        regWEn_i;
    logic [1:0]  wbSel_i;
    logic        loadSigned_i;
    logic [1:0]  dataSec_i;
    logic [31:0] pc4_i;
    logic [31:0] memData_i;
    logic [31:0] aluRes_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] rs1Data_o;
    logic [31:0] rs2Data_o;
    logic [31:0] wbData_o;
    logic [4:0]  wbRd_o;
    logic        wbEn_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: architectural registers plus the instruction waiting in write-back.
    logic [31:0] m_regs [32];
    logic        m_init  = 1'b0;
    logic        m_known = 1'b0;
    logic [4:0]  m_rd;
    logic        m_wen;
    logic [1:0]  m_sel;
    logic        m_sgn;
    logic [1:0]  m_sec;
    logic [31:0] m_pc4;

    always #5 clk = ~clk;

    wb_stage #(.CLR_REGS_ON_RST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .rd_i         (rd_i),
        .regWEn_i     (regWEn_i),
        .wbSel_i      (wbSel_i),
        .loadSigned_i (loadSigned_i),
        .dataSec_i    (dataSec_i),
        .pc4_i        (pc4_i),
        .memData_i    (memData_i),
        .aluRes_i     (aluRes_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rs1Data_o    (rs1Data_o),
        .rs2Data_o    (rs2Data_o),
        .wbData_o     (wbData_o),
        .wbRd_o       (wbRd_o),
        .wbEn_o       (wbEn_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Loaded value from the size/sign rules, using plain modular arithmetic.
    function automatic logic [31:0] m_load_value();
        logic [31:0] v;
        if (m_sec == 2'd0) begin
            v = memData_i % 32'd256;
            if (m_sgn && v >= 32'd128) v = v + 32'hffffff00;
        end else if (m_sec == 2'd1) begin
            v = memData_i % 32'd65536;
            if (m_sgn && v >= 32'd32768) v = v + 32'hffff0000;
        end else begin
            v = memData_i;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_wb_value();
        if (m_sel == 2'd0) return m_load_value();
        if (m_sel == 2'd1) return aluRes_i;
        if (m_sel == 2'd2) return m_pc4;
        return 32'h0;
    endfunction

    function automatic logic m_wb_en();
        return m_wen && (m_rd != 5'd0) && !stall_i;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (m_wb_en() && a == m_rd) return m_wb_value();
        return m_regs[a];
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic [4:0] rd,
                         input logic wen, input logic [1:0] sel, input logic sgn, input logic [1:0] sec,
                         input logic [31:0] pc4, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst = r; stall_i = s; flush_i = f; rd_i = rd; regWEn_i = wen; wbSel_i = sel;
        loadSigned_i = sgn; dataSec_i = sec; pc4_i = pc4; memData_i = mem; aluRes_i = alu;
        rs1_i = a1; rs2_i = a2;
    endtask

    // One clock: compare outputs with the model, take the edge, advance the model.
    task automatic step();
        logic        e_en;
        logic [31:0] e_wb;
        #1;
        e_en = m_wb_en();
        e_wb = m_wb_value();
        if (m_init) begin
            check("wb_en", 32'(wbEn_o), 32'(e_en));
            check("rs1_data", rs1Data_o, m_read(rs1_i));
            check("rs2_data", rs2Data_o, m_read(rs2_i));
            if (m_known) begin
                check("wb_rd", 32'(wbRd_o), 32'(m_rd));
                check("wb_data", wbData_o, e_wb);
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_init = 1'b1; m_known = 1'b1;
            m_rd = 5'd0; m_wen = 1'b0; m_sel = 2'd1; m_sgn = 1'b0; m_sec = 2'd0; m_pc4 = 32'h0;
        end else begin
            if (e_en) m_regs[m_rd] = e_wb;
            if (flush_i) begin
                m_wen = 1'b0; m_known = 1'b0;
            end else if (!stall_i) begin
                m_rd = rd_i; m_wen = regWEn_i; m_sel = wbSel_i; m_sgn = loadSigned_i;
                m_sec = dataSec_i; m_pc4 = pc4_i; m_known = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 0, 0, 5'd0, 0, 2'd0, 0, 2'd0, 32'h0, 32'hffffffff, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        step();
        step();

        // Out of reset: nothing written, memory reset value ignored.
        drive(1'b0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'hffffffff, 32'h0, 5'd5, 5'd0);
        #1;
        check("rst_rs1_x5", rs1Data_o, 32'h0);
        check("rst_wb_en", 32'(wbEn_o), 32'h0);
        check("rst_wb_rd", 32'(wbRd_o), 32'h0);
        step();

        // Signed then unsigned byte load of 0x80 into x3.
        drive(0, 0, 0, 5'd3, 1, 2'd0, 1, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        drive(0, 0, 0, 5'd3, 1, 2'd0, 0, 2'd0, 32'h0, 32'h00000080, 32'h0, 5'd3, 5'd0);
        #1;
        check("lb_signed", wbData_o, 32'hffffff80);
        check("lb_signed_bypass", rs1Data_o, 32'hffffff80);
        step();
        drive(0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'h00000080, 32'h0, 5'd3, 5'd0);
        #1;
        check("lbu", wbData_o, 32'h00000080);
        step();
        drive(0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
        #1;
        check("x3_stored", rs1Data_o, 32'h00000080);
        step();

        // ALU write to x7 with both read ports bypassing in the write cycle.
        drive(0, 0, 0, 5'd7, 1, 2'd1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        drive(0, 0, 0, 5'd0, 1, 2'd1, 0, 2'd0, 32'h0, 32'hffffffff, 32'h12345678, 5'd7, 5'd7);
        #1;
        check("alu_byp_rs1", rs1Data_o, 32'h12345678);
        check("alu_byp_rs2", rs2Data_o, 32'h12345678);
        step();
        // rd=0 with write enable: suppressed, x0 reads 0.
        drive(0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'h0, 32'hdeadbeef, 5'd0, 5'd7);
        #1;
        check("x0_wb_en", 32'(wbEn_o), 32'h0);
        check("x0_read", rs1Data_o, 32'h0);
        check("x7_stored", rs2Data_o, 32'h12345678);
        step();

        // pc+4 write to x9 held through two stall cycles.
        drive(0, 0, 0, 5'd9, 1, 2'd2, 0, 2'd0, 32'h00001000, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 5'd10, 1, 2'd1, 0, 2'd0, 32'h00002000, 32'h0, 32'h55, 5'd9, 5'd0);
            #1;
            check("stall_wb_en", 32'(wbEn_o), 32'h0);
            check("stall_wb_rd", 32'(wbRd_o), 32'd9);
            check("stall_x9", rs1Data_o, 32'h0);
            step();
        end
        drive(0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0);
        #1;
        check("unstall_wb_en", 32'(wbEn_o), 32'h1);
        check("unstall_wb_data", wbData_o, 32'h00001000);
        step();
        drive(0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0);
        #1;
        check("x9_stored", rs1Data_o, 32'h00001000);
        check("x9_single_write", 32'(wbEn_o), 32'h0);
        step();

        // Flush beats stall on a half load to x4 (x4 preset to 0x55).
        drive(0, 0, 0, 5'd4, 1, 2'd1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        drive(0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'h0, 32'h55, 5'd0, 5'd0);
        step();
        drive(0, 1, 1, 5'd4, 1, 2'd0, 1, 2'd1, 32'h0, 32'h0000ffff, 32'h0, 5'd0, 5'd0);
        step();
        drive(0, 0, 0, 5'd0, 0, 2'd1, 0, 2'd0, 32'h0, 32'h0000ffff, 32'h0, 5'd4, 5'd0);
        #1;
        check("flush_wb_en", 32'(wbEn_o), 32'h0);
        check("flush_x4", rs1Data_o, 32'h55);
        step();

        // Random traffic against the model, including occasional mid-run reset.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a1;
            logic [4:0] a2;
            a1 = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
            a2 = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
                  5'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                  $urandom, $urandom, $urandom, a1, a2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
